// File: rtl/lut_layer_scheduler_if.sv
// ---------------------------------------------------------------------------
// lut_layer_scheduler_if
//
// Bundles the frame stream, the result stream and the configuration port of
// lut_layer_scheduler so they travel as one object.
//
// Signals:
//   in_valid / in_ready / in_data    input frame handshake, 2 bits per feature
//   out_valid / out_ready / out_data result frame handshake, 2 bits per neuron
//   cfg_we / cfg_sel / cfg_addr / cfg_data
//                                    table and connectivity write port
//   cfg_err                          one-cycle pulse for a rejected write
//   busy                             scheduler is evaluating or holding a result
//
// Modports:
//   master  the side that produces frames and configuration
//   slave   the scheduler itself
// ---------------------------------------------------------------------------
interface lut_layer_scheduler_if #(
   parameter int N_IN  = 16,
   parameter int N_OUT = 8
);

   logic                 in_valid;
   logic                 in_ready;
   logic [2*N_IN-1:0]    in_data;

   logic                 out_valid;
   logic                 out_ready;
   logic [2*N_OUT-1:0]   out_data;

   logic                 cfg_we;
   logic                 cfg_sel;
   logic [15:0]          cfg_addr;
   logic [15:0]          cfg_data;
   logic                 cfg_err;

   logic                 busy;

   modport master (
      output in_valid, in_data, out_ready,
      output cfg_we, cfg_sel, cfg_addr, cfg_data,
      input  in_ready, out_valid, out_data, cfg_err, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      input  cfg_we, cfg_sel, cfg_addr, cfg_data,
      output in_ready, out_valid, out_data, cfg_err, busy
   );

endinterface

// File: rtl/lut_layer_scheduler.sv
// ---------------------------------------------------------------------------
// lut_layer_scheduler
//
// Time-multiplexes N_OUT lookup-table neurons onto one shared 6-in/2-out
// truth-table engine. A frame of N_IN 2-bit features is captured, then one
// neuron is evaluated per cycle: its three inputs are picked from the frame
// through the connectivity table, concatenated into a 6-bit index, and the
// neuron's own 64-entry truth table gives its 2-bit output. After the last
// neuron the packed result is offered on the output handshake.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous, active-high reset (table contents are kept)
//   bus   lut_layer_scheduler_if.slave
//           in_*    frame input handshake
//           out_*   result output handshake
//           cfg_*   table writes; cfg_sel 0 = truth table (addr k*64+idx),
//                   1 = connectivity (addr k*3+j)
//           busy    high while evaluating or holding a result
// ---------------------------------------------------------------------------
module lut_layer_scheduler #(
   parameter int N_IN  = 16,
   parameter int N_OUT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   lut_layer_scheduler_if.slave  bus
);

   localparam int CW         = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int KW         = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int TT_DEPTH   = N_OUT * 64;
   localparam int CONN_DEPTH = N_OUT * 3;
   localparam int TTAW       = $clog2(TT_DEPTH);
   localparam int CAW        = $clog2(CONN_DEPTH);

   localparam logic [16:0]   TT_LIMIT   = 17'(TT_DEPTH);
   localparam logic [16:0]   CONN_LIMIT = 17'(CONN_DEPTH);
   localparam logic [16:0]   IN_LIMIT   = 17'(N_IN);
   localparam logic [KW-1:0] LAST_K     = KW'(N_OUT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EVAL = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic [KW-1:0]       cnt;
   logic [2*N_IN-1:0]   frame;
   logic [2*N_OUT-1:0]  result;
   logic                cfg_err_q;

   logic [1:0]          tt_mem    [TT_DEPTH];
   logic [CW-1:0]       conn_idx  [CONN_DEPTH];
   logic                conn_oor  [CONN_DEPTH];

   logic [1:0]          feat      [N_IN];
   logic [5:0]          tbl_idx;
   logic [CAW-1:0]      conn_addr;
   logic [TTAW-1:0]     tt_addr;
   logic [1:0]          tbl_out;

   logic                in_ready_int;
   logic                cfg_in_range;
   logic                cfg_accept;

   // A configuration strobe always wins over a frame in IDLE, so the
   // scheduler refuses frames in any cycle that carries a write attempt.
   assign in_ready_int  = (state == S_IDLE) && !bus.cfg_we;

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = (state == S_DONE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.out_data  = result;
   assign bus.cfg_err   = cfg_err_q;

   // Writes are only honoured while idle and with an address inside the
   // selected store; everything else is dropped and flagged on cfg_err.
   always_comb begin
      cfg_in_range = 1'b0;
      if (bus.cfg_sel) begin
         cfg_in_range = ({1'b0, bus.cfg_addr} < CONN_LIMIT);
      end else begin
         cfg_in_range = ({1'b0, bus.cfg_addr} < TT_LIMIT);
      end
      cfg_accept = bus.cfg_we && (state == S_IDLE) && cfg_in_range;
   end

   // Table storage carries no reset so a reset never disturbs a loaded
   // network. The connectivity store keeps an out-of-range flag next to the
   // truncated index, so feature numbers at or above N_IN can be recognised
   // at evaluation time and forced to a zero field.
   always_ff @(posedge clk) begin
      if (!rst && cfg_accept) begin
         if (bus.cfg_sel) begin
            conn_idx[bus.cfg_addr[CAW-1:0]] <= bus.cfg_data[CW-1:0];
            conn_oor[bus.cfg_addr[CAW-1:0]] <= ({1'b0, bus.cfg_data} >= IN_LIMIT);
         end else begin
            tt_mem[bus.cfg_addr[TTAW-1:0]] <= bus.cfg_data[1:0];
         end
      end
   end

   // Unpack the captured frame into individual 2-bit features so they can
   // be selected by connectivity index.
   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         feat[i] = frame[2*i +: 2];
      end
   end

   // Build the truth-table index for the neuron the counter points at:
   // input j of neuron k comes from conn[k*3+j] and lands in index bits
   // [2j+1:2j]. The table entry for that neuron and index is its output.
   always_comb begin
      tbl_idx   = '0;
      conn_addr = '0;
      for (int j = 0; j < 3; j++) begin
         conn_addr = CAW'(int'(cnt) * 3 + j);
         if (!conn_oor[conn_addr]) begin
            tbl_idx[2*j +: 2] = feat[conn_idx[conn_addr]];
         end
      end
      tt_addr = TTAW'(int'(cnt) * 64 + int'(tbl_idx));
      tbl_out = tt_mem[tt_addr];
   end

   // Scheduler state machine. IDLE captures a frame, EVAL walks the neurons
   // one per cycle writing each output into its slot of the result, DONE
   // holds the result until the consumer takes it. cfg_err is registered so
   // a rejected write shows up as a single-cycle pulse after the attempt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         frame     <= '0;
         result    <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= bus.cfg_we && !cfg_accept;
         case (state)
            S_IDLE: begin
               if (bus.in_valid && in_ready_int) begin
                  frame <= bus.in_data;
                  cnt   <= '0;
                  state <= S_EVAL;
               end
            end
            S_EVAL: begin
               result[{cnt, 1'b0} +: 2] <= tbl_out;
               if (cnt == LAST_K) begin
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lut_layer_scheduler
//
// Directed bench for lut_layer_scheduler with N_IN=16, N_OUT=8. The network
// is loaded with conn[k*3+0]=2, conn[k*3+1]=1, conn[k*3+2]=0 and
// tt[k*64+idx] = idx[1:0] ^ k[1:0], so neuron k's output is the feature
// picked by input 0 (feature 2) XOR k[1:0]. Outputs are sampled 1 time unit
// after the rising edge; a value seen there is the one presented at the
// following edge.
// ---------------------------------------------------------------------------
module tb_lut_layer_scheduler;

   localparam int N_IN  = 16;
   localparam int N_OUT = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   lut_layer_scheduler_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

   lut_layer_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // One comparison: count it, and on mismatch count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle configuration write.
   task automatic cfgWrite(input logic sel, input int addr, input int data);
      bus.cfg_sel  = sel;
      bus.cfg_addr = 16'(addr);
      bus.cfg_data = 16'(data);
      bus.cfg_we   = 1'b1;
      tick();
      bus.cfg_we   = 1'b0;
   endtask

   // Offer a frame and return just after the accepting edge, with the
   // input bus then scrambled so late changes would corrupt a bad design.
   task automatic applyStimulus(input logic [31:0] frameData);
      int waited;
      waited       = 0;
      bus.in_data  = frameData;
      bus.in_valid = 1'b1;
      #1;
      while (bus.in_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      checkOutput("accept_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = 32'hFFFF_FFFF;
   endtask

   // Wait for the result, checking latency, that in_ready stayed low while
   // evaluating, the result value, and (with out_ready high) the return to
   // IDLE one edge later.
   task automatic finishFrame(input string tag, input int expLat,
                              input logic [31:0] expected);
      int lat;
      int leaks;
      lat   = 0;
      leaks = 0;
      while (bus.out_valid !== 1'b1 && lat < 50) begin
         if (bus.in_ready !== 1'b0) leaks++;
         tick();
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_inready_eval"}, 32'(leaks), 32'd0);
      checkOutput({tag, "_data"}, 32'(bus.out_data), expected);
      if (bus.out_ready === 1'b1) begin
         tick();
         checkOutput({tag, "_idle"}, {30'd0, bus.busy, bus.out_valid}, 32'd0);
      end
   endtask

   task automatic runFrame(input string tag, input logic [31:0] frameData,
                           input logic [31:0] expected);
      applyStimulus(frameData);
      finishFrame(tag, N_OUT, expected);
   endtask

   initial begin
      int bad;

      $display("[TB] start");
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_sel   = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
      checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);

      // Load the network described in the header.
      for (int k = 0; k < N_OUT; k++) begin
         cfgWrite(1'b1, k*3 + 0, 2);
         cfgWrite(1'b1, k*3 + 1, 1);
         cfgWrite(1'b1, k*3 + 2, 0);
      end
      for (int k = 0; k < N_OUT; k++) begin
         for (int idx = 0; idx < 64; idx++) begin
            cfgWrite(1'b0, k*64 + idx, (idx & 3) ^ (k & 3));
         end
      end
      checkOutput("cfg_err_valid_write", 32'(bus.cfg_err), 32'd0);

      // Features 0,1,2 = 2,1,3: input 0 sees 3, outputs 3^k -> 3,2,1,0,...
      runFrame("basic", 32'h0000_0036, 32'h0000_1B1B);

      // Features 0,1,2 = 1,0,0: input 0 sees 0, outputs k[1:0] -> 16'hE4E4.
      bus.out_ready = 1'b0;
      applyStimulus(32'h0000_0001);
      finishFrame("bp", N_OUT, 32'h0000_E4E4);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0036;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_data !== 16'hE4E4 || bus.busy !== 1'b1 ||
             bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
         tick();
      end
      checkOutput("bp_hold_cycles_bad", 32'(bad), 32'd0);
      checkOutput("bp_data_after_hold", 32'(bus.out_data), 32'h0000_E4E4);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      checkOutput("bp_idle", {30'd0, bus.busy, bus.out_valid}, 32'd0);

      // Collision: neuron 0 index for features 2,1,3 is 6'b10_01_11 = 39.
      // Clearing tt[39] turns neuron 0's output from 3 into 0.
      bus.in_data  = 32'h0000_0036;
      bus.in_valid = 1'b1;
      bus.cfg_sel  = 1'b0;
      bus.cfg_addr = 16'd39;
      bus.cfg_data = 16'd0;
      bus.cfg_we   = 1'b1;
      #1;
      checkOutput("coll_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      bus.cfg_we = 1'b0;
      checkOutput("coll_not_accepted", 32'(bus.busy), 32'd0);
      checkOutput("coll_cfg_err", 32'(bus.cfg_err), 32'd0);
      runFrame("coll", 32'h0000_0036, 32'h0000_1B18);

      // Write during EVAL to tt[64+39] must be dropped (neuron 1 stays 2).
      applyStimulus(32'h0000_0036);
      bus.cfg_sel  = 1'b0;
      bus.cfg_addr = 16'd103;
      bus.cfg_data = 16'd0;
      bus.cfg_we   = 1'b1;
      tick();
      bus.cfg_we = 1'b0;
      checkOutput("rej_eval_err", 32'(bus.cfg_err), 32'd1);
      tick();
      checkOutput("rej_eval_err_pulse", 32'(bus.cfg_err), 32'd0);
      finishFrame("rej_eval", N_OUT - 2, 32'h0000_1B18);

      // Address 512 is past the table; an aliasing write would hit tt[0].
      cfgWrite(1'b0, 512, 3);
      checkOutput("rej_range_err", 32'(bus.cfg_err), 32'd1);
      tick();
      checkOutput("rej_range_err_pulse", 32'(bus.cfg_err), 32'd0);
      runFrame("rej_alias", 32'h0000_0000, 32'h0000_E4E4);
      runFrame("rej_rerun", 32'h0000_0036, 32'h0000_1B18);

      // conn[1] = 17: neuron 0 input 1 becomes 00, index 6'b10_00_11 = 35,
      // tt[35] = 3. A truncated index 1 would give index 39 -> 0 instead.
      cfgWrite(1'b1, 1, 17);
      runFrame("oor", 32'h0000_0036, 32'h0000_1B1B);
      cfgWrite(1'b1, 1, 1);

      // Reset with the counter at 4; a write and a frame during reset are
      // both ignored (the write would set tt[39] back to 3).
      applyStimulus(32'h0000_0036);
      repeat (4) tick();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0036;
      bus.cfg_sel  = 1'b0;
      bus.cfg_addr = 16'd39;
      bus.cfg_data = 16'd3;
      bus.cfg_we   = 1'b1;
      tick();
      checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("midrst_out_data", 32'(bus.out_data), 32'd0);
      checkOutput("midrst_cfg_err", 32'(bus.cfg_err), 32'd0);
      tick();
      rst          = 1'b0;
      bus.cfg_we   = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
         tick();
      end
      checkOutput("midrst_no_out_valid", 32'(bad), 32'd0);
      runFrame("post_reset", 32'h0000_0036, 32'h0000_1B18);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
